// File: rtl/chip_dma_pkg.sv
// Shared owner codes, slot map and DMACON bit positions
// for the chip-bus DMA slot scheduler.
package chip_dma_pkg;

   localparam int HPOS_W = 9;

   typedef enum logic [3:0] {
      OWN_IDLE = 4'd0,
      OWN_REF  = 4'd1,
      OWN_DSK  = 4'd2,
      OWN_AUD  = 4'd3,
      OWN_SPR  = 4'd4,
      OWN_BPL  = 4'd5,
      OWN_COP  = 4'd6,
      OWN_BLT  = 4'd7,
      OWN_CPU  = 4'd8
   } owner_e;

   localparam logic [HPOS_W-1:0] REF_SLOT0     = 9'h001;
   localparam logic [HPOS_W-1:0] DSK_SLOT0     = 9'h009;
   localparam logic [HPOS_W-1:0] AUD_SLOT0     = 9'h00F;
   localparam logic [HPOS_W-1:0] SPR_SLOT0     = 9'h017;
   localparam logic [HPOS_W-1:0] SPR_SLOT_LAST = 9'h035;

   localparam int DMA_DMAEN = 9;
   localparam int DMA_BPLEN = 8;
   localparam int DMA_COPEN = 7;
   localparam int DMA_BLTEN = 6;
   localparam int DMA_SPREN = 5;
   localparam int DMA_DSKEN = 4;

endpackage

// File: rtl/chip_dma_hctr.sv
// Horizontal beam counter in CCK units with NTSC long/short
// line alternation and a one-clock line start strobe.
module chip_dma_hctr
   import chip_dma_pkg::*;
#(
   parameter int HTOT_SHORT = 227,
   parameter int HTOT_LONG  = 228
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cck_ena_i,
   input  logic              ntscn_pal_i,
   output logic [HPOS_W-1:0] hpos_o,
   output logic [HPOS_W-1:0] hpos_next_o,
   output logic              lol_o,
   output logic              line_strt_o
);

   logic [HPOS_W-1:0] hpos_q, hpos_d;
   logic [HPOS_W-1:0] hpos_last;
   logic              lol_q, lol_d;
   logic              line_strt_q, line_strt_d;
   logic              wrap;

   assign hpos_last = lol_q ? HPOS_W'(HTOT_LONG - 1)
                            : HPOS_W'(HTOT_SHORT - 1);
   assign wrap        = (hpos_q == hpos_last);
   assign hpos_next_o = wrap ? '0 : hpos_q + HPOS_W'(1);

   // PAL always runs short lines; NTSC alternates at every wrap
   always_comb begin
      hpos_d      = hpos_q;
      lol_d       = lol_q;
      line_strt_d = 1'b0;
      if (cck_ena_i) begin
         hpos_d      = hpos_next_o;
         line_strt_d = wrap;
         if (wrap) begin
            lol_d = ~ntscn_pal_i & ~lol_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hpos_q      <= '0;
         lol_q       <= 1'b0;
         line_strt_q <= 1'b0;
      end else begin
         hpos_q      <= hpos_d;
         lol_q       <= lol_d;
         line_strt_q <= line_strt_d;
      end
   end

   assign hpos_o      = hpos_q;
   assign lol_o       = lol_q;
   assign line_strt_o = line_strt_q;

endmodule

// File: rtl/chip_dma_slot_sched.sv
// Per-CCK chip-bus owner selection: fixed-slot DMA, bitplane
// steal, copper, blitter with CPU nice-mode fairness, CPU.
module chip_dma_slot_sched
   import chip_dma_pkg::*;
#(
   parameter int HTOT_SHORT = 227,
   parameter int HTOT_LONG  = 228,
   parameter int NICE_LIMIT = 3
) (
   input  logic              main_clk,
   input  logic              main_rst,
   input  logic              cck_ena,
   input  logic              ntscn_pal,
   input  logic [9:0]        dmacon,
   input  logic              bltpri,
   input  logic              dsk_req,
   input  logic [3:0]        aud_req,
   input  logic [7:0]        spr_req,
   input  logic              bpl_req,
   input  logic              cop_req,
   input  logic              blt_req,
   input  logic              cpu_req,
   output logic [HPOS_W-1:0] hpos,
   output logic              lol,
   output logic              line_strt,
   output logic [3:0]        own,
   output logic [2:0]        own_idx,
   output logic              cpu_gnt
);

   localparam int NICE_W = $clog2(NICE_LIMIT + 1);
   localparam logic [NICE_W-1:0] NICE_MAX = NICE_W'(NICE_LIMIT);

   logic [HPOS_W-1:0] slot;
   logic              ref_slot, dsk_slot, aud_slot, spr_slot;
   logic [1:0]        aud_k;
   logic [2:0]        spr_n;
   logic              forced_cpu;

   owner_e            own_q, own_d;
   logic [2:0]        idx_q, idx_d;
   logic [NICE_W-1:0] nice_q, nice_d;

   chip_dma_hctr #(
      .HTOT_SHORT (HTOT_SHORT),
      .HTOT_LONG  (HTOT_LONG)
   ) u_hctr (
      .clk_i       (main_clk),
      .rst_i       (main_rst),
      .cck_ena_i   (cck_ena),
      .ntscn_pal_i (ntscn_pal),
      .hpos_o      (hpos),
      .hpos_next_o (slot),
      .lol_o       (lol),
      .line_strt_o (line_strt)
   );

   assign ref_slot = slot[0] && (slot <= REF_SLOT0 + 9'd6);
   assign dsk_slot = (slot == DSK_SLOT0)
                  || (slot == DSK_SLOT0 + 9'd2)
                  || (slot == DSK_SLOT0 + 9'd4);
   assign aud_slot = slot[0] && (slot >= AUD_SLOT0)
                  && (slot <= AUD_SLOT0 + 9'd6);
   assign spr_slot = slot[0] && (slot >= SPR_SLOT0)
                  && (slot <= SPR_SLOT_LAST);
   assign aud_k    = 2'((slot - AUD_SLOT0) >> 1);
   assign spr_n    = 3'((slot - SPR_SLOT0) >> 2);

   assign forced_cpu = !bltpri && (nice_q == NICE_MAX);

   // Bitplane fetch may only steal sprite and free slots
   always_comb begin
      own_d = OWN_IDLE;
      idx_d = '0;
      if (ref_slot) begin
         own_d = OWN_REF;
      end else if (!dmacon[DMA_DMAEN]) begin
         own_d = cpu_req ? OWN_CPU : OWN_IDLE;
      end else if (bpl_req && dmacon[DMA_BPLEN]
                   && !dsk_slot && !aud_slot) begin
         own_d = OWN_BPL;
      end else if (dsk_slot && dmacon[DMA_DSKEN] && dsk_req) begin
         own_d = OWN_DSK;
      end else if (aud_slot && dmacon[aud_k] && aud_req[aud_k]) begin
         own_d = OWN_AUD;
         idx_d = {1'b0, aud_k};
      end else if (spr_slot && dmacon[DMA_SPREN] && spr_req[spr_n]) begin
         own_d = OWN_SPR;
         idx_d = spr_n;
      end else if (!slot[0] && dmacon[DMA_COPEN] && cop_req) begin
         own_d = OWN_COP;
      end else if (dmacon[DMA_BLTEN] && blt_req && !forced_cpu) begin
         own_d = OWN_BLT;
      end else if (cpu_req) begin
         own_d = OWN_CPU;
      end
   end

   always_comb begin
      nice_d = nice_q;
      if (own_d == OWN_BLT && cpu_req) begin
         if (nice_q != NICE_MAX) begin
            nice_d = nice_q + NICE_W'(1);
         end
      end else if (own_d == OWN_CPU || !cpu_req) begin
         nice_d = '0;
      end
   end

   always_ff @(posedge main_clk) begin
      if (main_rst) begin
         own_q  <= OWN_IDLE;
         idx_q  <= '0;
         nice_q <= '0;
      end else if (cck_ena) begin
         own_q  <= own_d;
         idx_q  <= idx_d;
         nice_q <= nice_d;
      end
   end

   assign own     = own_q;
   assign own_idx = idx_q;
   assign cpu_gnt = (own_q == OWN_CPU);

endmodule

// File: tb/tb_chip_dma_slot_sched.sv
// Randomised and directed bench for chip_dma_slot_sched
// against a slot-table reference model.
module tb_chip_dma_slot_sched;

   logic       main_clk = 1'b0;
   logic       main_rst, cck_ena, ntscn_pal;
   logic [9:0] dmacon;
   logic       bltpri, dsk_req, bpl_req, cop_req, blt_req, cpu_req;
   logic [3:0] aud_req;
   logic [7:0] spr_req;
   logic [8:0] hpos;
   logic       lol, line_strt, cpu_gnt;
   logic [3:0] own;
   logic [2:0] own_idx;

   int n_chk = 0;
   int n_err = 0;

   int m_hpos, m_lol, m_cnt, m_own, m_idx;
   bit last_ls;

   always #5 main_clk = ~main_clk;

   chip_dma_slot_sched dut (
      .main_clk  (main_clk),
      .main_rst  (main_rst),
      .cck_ena   (cck_ena),
      .ntscn_pal (ntscn_pal),
      .dmacon    (dmacon),
      .bltpri    (bltpri),
      .dsk_req   (dsk_req),
      .aud_req   (aud_req),
      .spr_req   (spr_req),
      .bpl_req   (bpl_req),
      .cop_req   (cop_req),
      .blt_req   (blt_req),
      .cpu_req   (cpu_req),
      .hpos      (hpos),
      .lol       (lol),
      .line_strt (line_strt),
      .own       (own),
      .own_idx   (own_idx),
      .cpu_gnt   (cpu_gnt)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at hpos model %0h",
                  tag, obs, exp, m_hpos);
      end
   endtask

   // Slot table of the bus: which fixed owner a slot belongs to
   task automatic ref_grant(input int s, output int o, output int ix);
      bit is_dsk, is_aud, is_spr;
      int k, n;
      o  = 0;
      ix = 0;
      is_dsk = (s == 9) || (s == 11) || (s == 13);
      is_aud = (s >= 15) && (s <= 21) && (s % 2 == 1);
      is_spr = (s >= 23) && (s <= 53) && (s % 2 == 1);
      k = (s - 15) / 2;
      n = (s - 23) / 4;
      if (s >= 1 && s <= 7 && s % 2 == 1) o = 1;
      else if (!dmacon[9]) o = cpu_req ? 8 : 0;
      else if (bpl_req && dmacon[8] && !is_dsk && !is_aud) o = 5;
      else if (is_dsk && dmacon[4] && dsk_req) o = 2;
      else if (is_aud && dmacon[k] && aud_req[k]) begin
         o  = 3;
         ix = k;
      end else if (is_spr && dmacon[5] && spr_req[n]) begin
         o  = 4;
         ix = n;
      end else if (s % 2 == 0 && dmacon[7] && cop_req) o = 6;
      else if (dmacon[6] && blt_req && !(!bltpri && m_cnt == 3)) o = 7;
      else if (cpu_req) o = 8;
   endtask

   task automatic chk_state(input bit exp_ls);
      chk("hpos", hpos, m_hpos);
      chk("lol", lol, m_lol);
      chk("own", own, m_own);
      chk("own_idx", own_idx, m_idx);
      chk("cpu_gnt", cpu_gnt, (m_own == 8));
      chk("line_strt", line_strt, exp_ls);
   endtask

   task automatic pulse();
      int  htot, s, o, ix;
      bit  wrap;
      @(negedge main_clk);
      cck_ena = 1'b1;
      htot = m_lol ? 228 : 227;
      wrap = (m_hpos == htot - 1);
      s    = wrap ? 0 : m_hpos + 1;
      ref_grant(s, o, ix);
      if (o == 7 && cpu_req) begin
         if (m_cnt < 3) m_cnt++;
      end else if (o == 8 || !cpu_req) begin
         m_cnt = 0;
      end
      m_hpos = s;
      if (wrap) m_lol = ntscn_pal ? 0 : (m_lol ^ 1);
      m_own = o;
      m_idx = ix;
      @(posedge main_clk);
      #1;
      cck_ena = 1'b0;
      last_ls = line_strt;
      chk_state(wrap);
      @(posedge main_clk);
      #1;
      chk("ls_drop", line_strt, 0);
      chk("hpos_hold", hpos, m_hpos);
      chk("own_hold", own, m_own);
   endtask

   task automatic do_reset(input bit with_cck);
      @(negedge main_clk);
      main_rst = 1'b1;
      cck_ena  = with_cck;
      @(posedge main_clk);
      #1;
      main_rst = 1'b0;
      cck_ena  = 1'b0;
      m_hpos = 0;
      m_lol  = 0;
      m_cnt  = 0;
      m_own  = 0;
      m_idx  = 0;
      chk_state(1'b0);
   endtask

   task automatic clear_inputs();
      dmacon  = 10'h200;
      bltpri  = 0;
      dsk_req = 0;
      aud_req = '0;
      spr_req = '0;
      bpl_req = 0;
      cop_req = 0;
      blt_req = 0;
      cpu_req = 0;
   endtask

   task automatic advance_to(input int target);
      int n = 0;
      while (m_hpos != target && n < 600) begin
         pulse();
         n++;
      end
      chk("advance_hpos", hpos, target);
   endtask

   task automatic line_len(input int exp_len, input int exp_lol);
      int n = 0;
      last_ls = 0;
      while (!last_ls && n < 300) begin
         pulse();
         n++;
      end
      chk("line_len", n, exp_len);
      chk("line_lol", lol, exp_lol);
      chk("line_hpos0", hpos, 0);
   endtask

   initial begin
      int owners [8];
      int n;
      main_rst  = 0;
      cck_ena   = 0;
      ntscn_pal = 1;
      clear_inputs();

      do_reset(0);
      pulse();
      chk("first_hpos", hpos, 1);
      chk("first_own", own, 1);
      pulse();
      chk("second_hpos", hpos, 2);
      chk("second_own", own, 0);

      do_reset(0);
      line_len(227, 0);
      line_len(227, 0);
      ntscn_pal = 0;
      do_reset(0);
      line_len(227, 1);
      line_len(228, 0);
      line_len(227, 1);
      ntscn_pal = 1;
      line_len(228, 0);

      do_reset(0);
      dmacon  = 10'h205;
      aud_req = 4'hF;
      cpu_req = 1;
      advance_to(8'h0E);
      pulse(); chk("aud0_own", own, 3); chk("aud0_idx", own_idx, 0);
      pulse(); chk("aud_10", own, 8);
      pulse(); chk("aud1_own", own, 8); chk("aud1_idx", own_idx, 0);
      pulse(); chk("aud_12", own, 8);
      pulse(); chk("aud2_own", own, 3); chk("aud2_idx", own_idx, 2);
      pulse();
      pulse(); chk("aud3_own", own, 8); chk("aud3_gnt", cpu_gnt, 1);

      clear_inputs();
      do_reset(0);
      dmacon  = 10'h320;
      spr_req = 8'hFF;
      bpl_req = 1;
      advance_to(8'h16);
      for (int s = 8'h17; s <= 8'h36; s++) begin
         pulse();
         chk("bpl_steal", own, 5);
      end
      do_reset(0);
      bpl_req = 0;
      advance_to(8'h16);
      for (int s = 8'h17; s <= 8'h36; s++) begin
         pulse();
         if (s % 2 == 1 && s <= 8'h35) begin
            chk("spr_own", own, 4);
            chk("spr_idx", own_idx, (s - 8'h17) >> 2);
         end else begin
            chk("spr_gap", own, 0);
         end
      end

      clear_inputs();
      do_reset(0);
      dmacon  = 10'h240;
      blt_req = 1;
      cpu_req = 1;
      advance_to(8'h40);
      n = 0;
      while (own != 8 && n < 16) begin
         pulse();
         n++;
      end
      chk("nice_find", own, 8);
      for (int i = 0; i < 8; i++) begin
         pulse();
         owners[i] = own;
      end
      for (int i = 0; i < 8; i++)
         chk("nice_pat", owners[i], (i % 4 == 3) ? 8 : 7);
      bltpri = 1;
      for (int i = 0; i < 8; i++) begin
         pulse();
         chk("nasty_own", own, 7);
         chk("nasty_gnt", cpu_gnt, 0);
      end

      bltpri = 0;
      advance_to(8'h40);
      n = 0;
      while (m_cnt == 0 && n < 8) begin
         pulse();
         n++;
      end
      do_reset(1);
      for (int i = 1; i <= 8; i++) begin
         pulse();
         chk("rst_nice", own, (i % 2 == 1) ? 1 : ((i == 8) ? 8 : 7));
      end

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            dmacon  = 10'($urandom);
            if ($urandom_range(0, 3) != 0) dmacon[9] = 1'b1;
            bltpri  = 1'($urandom);
            dsk_req = 1'($urandom);
            aud_req = 4'($urandom);
            spr_req = 8'($urandom);
            bpl_req = ($urandom_range(0, 3) == 0);
            cop_req = 1'($urandom);
            blt_req = ($urandom_range(0, 3) != 0);
            cpu_req = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 499) == 0) ntscn_pal = ~ntscn_pal;
         if ($urandom_range(0, 999) == 0) do_reset(1'($urandom));
         else pulse();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
